// File: rtl/spi_cmd_sequencer.sv
`timescale 1ns/1ps
// spi_cmd_sequencer: buffers host register commands, issues them one at a time to the SPI
// master engine and collects read results. Define SPI_SEQ_READBACK_VERIFY_EN for write readback.

module spi_seq_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    // A pop frees a slot in the same cycle, so push-while-full is accepted alongside it
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

module spi_cmd_sequencer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   FSM_clk,
    input  logic                   reset_n,
    input  logic                   go,
    input  logic                   clear_err,
    input  logic                   cmd_wr_en,
    input  logic [15:0]            cmd_wr_data,
    output logic                   cmd_full,
    output logic [$clog2(DEPTH):0] cmd_count,
    input  logic                   res_rd_en,
    output logic [7:0]             res_rd_data,
    output logic                   res_empty,
    output logic [$clog2(DEPTH):0] res_count,
    output logic                   spi_start,
    output logic                   spi_rw,
    output logic [6:0]             spi_addr,
    output logic [7:0]             spi_wdata,
    input  logic [7:0]             spi_rdata,
    input  logic [3:0]             spi_state,
    output logic                   busy,
    output logic                   done,
    output logic                   err_timeout,
    output logic                   err_overflow,
    output logic                   err_mismatch
);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, CAPTURE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          start_q, start_d;
    logic          done_q, done_d;
    logic          busy_q;
    logic          rw_q;
    logic          spi_rw_q;
    logic [6:0]    addr_q;
    logic [7:0]    wdata_q;
    logic          err_timeout_q;
    logic          err_overflow_q;

    logic          load_c;
    logic          readback_c;
    logic          cmd_pop_c;
    logic          res_push_c;
    logic          to_err_c;
    logic          ovf_c;
    logic          tmo_c;
    logic          engine_idle_c;

    logic [15:0]   cmd_head;
    logic          cmd_empty;
    logic          res_full;

`ifdef SPI_SEQ_READBACK_VERIFY_EN
    logic          verify_q, verify_d;
    logic          mm_err_c;
    logic          err_mismatch_q;
`endif

    spi_seq_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk       (FSM_clk),
        .rst_n     (reset_n),
        .push      (cmd_wr_en),
        .push_data (cmd_wr_data),
        .pop       (cmd_pop_c),
        .head      (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty),
        .count     (cmd_count)
    );

    spi_seq_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_res_fifo (
        .clk       (FSM_clk),
        .rst_n     (reset_n),
        .push      (res_push_c),
        .push_data (spi_rdata),
        .pop       (res_rd_en),
        .head      (res_rd_data),
        .full      (res_full),
        .empty     (res_empty),
        .count     (res_count)
    );

    assign engine_idle_c = (spi_state == 4'd0);
    assign tmo_c         = (tmr_q == TW'(TIMEOUT - 1));
    assign ovf_c         = cmd_wr_en && cmd_full && !cmd_pop_c;

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        tmr_d      = '0;
        start_d    = start_q;
        done_d     = 1'b0;
        load_c     = 1'b0;
        readback_c = 1'b0;
        cmd_pop_c  = 1'b0;
        res_push_c = 1'b0;
        to_err_c   = 1'b0;
`ifdef SPI_SEQ_READBACK_VERIFY_EN
        verify_d   = verify_q;
        mm_err_c   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A read is held back while there is no room for its result
                if (go && !cmd_empty && engine_idle_c && (cmd_head[15] || !res_full)) begin
                    cmd_pop_c = 1'b1;
                    load_c    = 1'b1;
                    state_d   = ISSUE;
`ifdef SPI_SEQ_READBACK_VERIFY_EN
                    verify_d  = 1'b0;
`endif
                end
            end
            ISSUE: begin
                start_d = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!engine_idle_c) begin
                    start_d = 1'b0;
                    state_d = WAIT_DONE;
                end else if (tmo_c) begin
                    start_d  = 1'b0;
                    to_err_c = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (engine_idle_c) begin
                    state_d = CAPTURE;
                end else if (tmo_c) begin
                    to_err_c = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            CAPTURE: begin
                done_d     = 1'b1;
                res_push_c = ~rw_q;
                state_d    = IDLE;
`ifdef SPI_SEQ_READBACK_VERIFY_EN
                if (rw_q && !verify_q) begin
                    done_d     = 1'b0;
                    readback_c = 1'b1;
                    verify_d   = 1'b1;
                    state_d    = ISSUE;
                end else if (verify_q) begin
                    mm_err_c = (spi_rdata != wdata_q);
                    verify_d = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge FSM_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            start_q <= start_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Held command fields; the readback reuses address and data with rw forced low
    always_ff @(posedge FSM_clk or negedge reset_n) begin
        if (!reset_n) begin
            rw_q     <= 1'b0;
            spi_rw_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (load_c) begin
            rw_q     <= cmd_head[15];
            spi_rw_q <= cmd_head[15];
            addr_q   <= cmd_head[14:8];
            wdata_q  <= cmd_head[7:0];
        end else if (readback_c) begin
            spi_rw_q <= 1'b0;
        end
    end

    // Sticky errors: a new event in the clearing cycle wins
    always_ff @(posedge FSM_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            err_timeout_q  <= to_err_c | (err_timeout_q & ~clear_err);
            err_overflow_q <= ovf_c | (err_overflow_q & ~clear_err);
        end
    end

`ifdef SPI_SEQ_READBACK_VERIFY_EN
    always_ff @(posedge FSM_clk or negedge reset_n) begin
        if (!reset_n) begin
            verify_q       <= 1'b0;
            err_mismatch_q <= 1'b0;
        end else begin
            verify_q       <= verify_d;
            err_mismatch_q <= mm_err_c | (err_mismatch_q & ~clear_err);
        end
    end

    assign err_mismatch = err_mismatch_q;
`else
    assign err_mismatch = 1'b0;
`endif

    assign spi_start    = start_q;
    assign spi_rw       = spi_rw_q;
    assign spi_addr     = addr_q;
    assign spi_wdata    = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = err_overflow_q;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
`timescale 1ns/1ps
// Bench for spi_cmd_sequencer: behavioural SPI engine plus a command-level reference model.

module tb_spi_cmd_sequencer;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
`ifdef SPI_SEQ_READBACK_VERIFY_EN
    localparam int VERIFY = 1;
`else
    localparam int VERIFY = 0;
`endif

    logic          FSM_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          go = 1'b0;
    logic          clear_err = 1'b0;
    logic          cmd_wr_en = 1'b0;
    logic [15:0]   cmd_wr_data = '0;
    logic          cmd_full;
    logic [CW-1:0] cmd_count;
    logic          res_rd_en = 1'b0;
    logic [7:0]    res_rd_data;
    logic          res_empty;
    logic [CW-1:0] res_count;
    logic          spi_start;
    logic          spi_rw;
    logic [6:0]    spi_addr;
    logic [7:0]    spi_wdata;
    logic [7:0]    spi_rdata;
    logic [3:0]    spi_state;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          err_overflow;
    logic          err_mismatch;

    spi_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .FSM_clk      (FSM_clk),
        .reset_n      (reset_n),
        .go           (go),
        .clear_err    (clear_err),
        .cmd_wr_en    (cmd_wr_en),
        .cmd_wr_data  (cmd_wr_data),
        .cmd_full     (cmd_full),
        .cmd_count    (cmd_count),
        .res_rd_en    (res_rd_en),
        .res_rd_data  (res_rd_data),
        .res_empty    (res_empty),
        .res_count    (res_count),
        .spi_start    (spi_start),
        .spi_rw       (spi_rw),
        .spi_addr     (spi_addr),
        .spi_wdata    (spi_wdata),
        .spi_rdata    (spi_rdata),
        .spi_state    (spi_state),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow),
        .err_mismatch (err_mismatch)
    );

    always #10 FSM_clk = ~FSM_clk;

    // SPI engine model: no reset, 34 busy cycles per transfer
    int         eng_cnt = 0;
    int         txn_cnt = 0;
    logic [7:0] eng_mem [128];
    logic [7:0] eng_rdata = '0;
    bit         eng_init = 1'b0;
    bit         eng_en = 1'b1;
    bit         eng_corrupt = 1'b0;

    assign spi_state = (eng_cnt != 0) ? 4'd5 : 4'd0;
    assign spi_rdata = eng_rdata;

    always @(posedge FSM_clk) begin
        if (!eng_init) begin
            for (int a = 0; a < 128; a++) eng_mem[a] = 8'(a * 7 + 3);
            eng_init = 1'b1;
        end
        if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
        end else if (spi_start && eng_en) begin
            eng_cnt <= 34;
            txn_cnt <= txn_cnt + 1;
            if (spi_rw) eng_mem[spi_addr] = spi_wdata;
            else        eng_rdata <= eng_corrupt ? 8'hA4 : eng_mem[spi_addr];
        end
    end

    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   start_rise = 0;
    logic start_prev = 1'b0;

    always @(posedge FSM_clk) cyc <= cyc + 1;

    always @(negedge FSM_clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (spi_start && !start_prev) start_rise <= cyc;
        start_prev <= spi_start;
    end

    // Reference model: sensor register image and expected result stream
    logic [7:0] ref_regs [128];
    logic [7:0] exp_q [$];

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic rw, input logic [6:0] a, input logic [7:0] d);
        return {rw, a, d};
    endfunction

    function automatic void model_cmd(input logic [15:0] w);
        if (w[15]) ref_regs[w[14:8]] = w[7:0];
        else       exp_q.push_back(ref_regs[w[14:8]]);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge FSM_clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        cmd_wr_data = w;
        cmd_wr_en   = 1'b1;
        tick(1);
        cmd_wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy && cmd_count == '0 && spi_state == 4'd0) break;
            tick(1);
        end
        check("idle_reached", 32'({busy, cmd_count}), 32'd0);
        tick(2);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("res_data", 32'(res_rd_data), 32'(e));
            res_rd_en = 1'b1;
            tick(1);
            res_rd_en = 1'b0;
        end
        check("res_empty_after_drain", 32'(res_empty), 32'd1);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, d0, t0, k, viol, tto;
        logic [15:0] w;

        for (int a = 0; a < 128; a++) ref_regs[a] = 8'(a * 7 + 3);

        // Reset values
        tick(2);
        check("rst_start", 32'(spi_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_empty", 32'(res_empty), 32'd1);
        reset_n = 1'b1;
        tick(1);
        check("rst_counts", 32'({cmd_count, res_count}), 32'd0);
        check("rst_fields", 32'({spi_rw, spi_addr, spi_wdata}), 32'd0);
        check("rst_flags", 32'({done, cmd_full, err_timeout, err_overflow, err_mismatch}), 32'd0);

        // Single write: handshake timing and held fields
        go = 1'b1;
        d0 = done_cnt;
        t0 = txn_cnt;
        w  = mk(1'b1, 7'h0A, 8'h5C);
        push(w);
        model_cmd(w);
        n = cyc;
        check("t1_cmd_count", 32'(cmd_count), 32'd1);
        tick(1);
        check("t1_start_n1", 32'(spi_start), 32'd0);
        check("t1_busy_n1", 32'(busy), 32'd1);
        tick(1);
        check("t1_start_n2", 32'(spi_start), 32'd1);
        tick(1);
        check("t1_start_n3", 32'(spi_start), 32'd1);
        tick(1);
        check("t1_start_n4", 32'(spi_start), 32'd0);
        check("t1_fields", 32'({spi_rw, spi_addr, spi_wdata}), 32'({1'b1, 7'h0A, 8'h5C}));
        wait_idle(400);
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t1_done_cyc", 32'(done_cyc - n), 32'(39 + 38 * VERIFY));
        check("t1_txn", 32'(txn_cnt - t0), 32'(1 + VERIFY));
        check("t1_res_empty", 32'(res_empty), 32'd1);

        // Three reads returning 0x11, 0x22, 0x33 in order
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            w = mk(1'b1, 7'(i), 8'(8'h11 * (i + 1)));
            push(w);
            model_cmd(w);
        end
        for (int i = 0; i < 3; i++) begin
            w = mk(1'b0, 7'(i), 8'h00);
            push(w);
            model_cmd(w);
        end
        wait_idle(1500);
        check("t2_done_cnt", 32'(done_cnt - d0), 32'd6);
        check("t2_res_count", 32'(res_count), 32'd3);
        drain();
        res_rd_en = 1'b1;
        tick(1);
        res_rd_en = 1'b0;
        check("t2_pop_empty_ignored", 32'(res_count), 32'd0);

        // Randomized command batches with random host gaps
        for (int r = 0; r < 4; r++) begin
            d0 = done_cnt;
            k  = int'($urandom_range(3, 8));
            for (int i = 0; i < k; i++) begin
                w = mk(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 8'($urandom));
                push(w);
                model_cmd(w);
                tick(int'($urandom_range(0, 3)));
            end
            wait_idle(2000);
            check("rand_done_cnt", 32'(done_cnt - d0), 32'(k));
            check("rand_res_count", 32'(res_count), 32'(exp_q.size()));
            drain();
        end

        // Overflow with go low, clear, and clear colliding with a new overflow
        go = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 17; i++) begin
            w = mk(1'b1, 7'($urandom_range(16, 31)), 8'($urandom));
            push(w);
            if (i < 16) model_cmd(w);
        end
        check("ovf_count", 32'(cmd_count), 32'(DEPTH));
        check("ovf_full", 32'(cmd_full), 32'd1);
        check("ovf_flag", 32'(err_overflow), 32'd1);
        pulse_clear();
        check("ovf_cleared", 32'(err_overflow), 32'd0);
        cmd_wr_data = 16'hFFFF;
        cmd_wr_en   = 1'b1;
        clear_err   = 1'b1;
        tick(1);
        cmd_wr_en   = 1'b0;
        clear_err   = 1'b0;
        check("ovf_err_wins", 32'(err_overflow), 32'd1);
        check("ovf_count_kept", 32'(cmd_count), 32'(DEPTH));
        pulse_clear();
        go = 1'b1;
        wait_idle(4000);
        check("ovf_flush_done", 32'(done_cnt - d0), 32'(DEPTH));
        check("ovf_full_after", 32'(cmd_full), 32'd0);

        // Ack timeout: first command discarded, next one runs
        go     = 1'b0;
        eng_en = 1'b0;
        push(mk(1'b1, 7'h20, 8'h99));
        w = mk(1'b0, 7'h20, 8'h00);
        push(w);
        model_cmd(w);
        d0 = done_cnt;
        t0 = txn_cnt;
        go = 1'b1;
        tto = 0;
        for (int i = 0; i < 600; i++) begin
            tick(1);
            if (err_timeout) begin
                tto = cyc;
                break;
            end
        end
        check("to_flag", 32'(err_timeout), 32'd1);
        check("to_latency", 32'(tto - start_rise), 32'(TIMEOUT));
        check("to_start_low", 32'(spi_start), 32'd0);
        check("to_no_done", 32'(done_cnt - d0), 32'd0);
        eng_en = 1'b1;
        wait_idle(600);
        check("to_next_done", 32'(done_cnt - d0), 32'd1);
        check("to_next_txn", 32'(txn_cnt - t0), 32'd1);
        drain();
        pulse_clear();
        check("to_cleared", 32'(err_timeout), 32'd0);

        // Reset during a read with the engine still busy
        push(mk(1'b0, 7'h05, 8'h00));
        for (int i = 0; i < 50 && eng_cnt == 0; i++) tick(1);
        tick(5);
        reset_n = 1'b0;
        #1;
        check("mrst_outputs", 32'({spi_start, busy, done, cmd_count}), 32'd0);
        check("mrst_fields", 32'({spi_rw, spi_addr, spi_wdata}), 32'd0);
        check("mrst_res_empty", 32'(res_empty), 32'd1);
        tick(1);
        reset_n = 1'b1;
        check("mrst_engine_busy", 32'(eng_cnt != 0), 32'd1);
        d0 = done_cnt;
        w  = mk(1'b1, 7'h05, 8'h6B);
        push(w);
        model_cmd(w);
        viol = 0;
        for (int i = 0; i < 100 && eng_cnt != 0; i++) begin
            if (spi_start) viol++;
            tick(1);
        end
        check("mrst_no_early_start", 32'(viol), 32'd0);
        w = mk(1'b0, 7'h05, 8'h00);
        push(w);
        model_cmd(w);
        wait_idle(1000);
        check("mrst_done", 32'(done_cnt - d0), 32'd2);
        drain();

        // Write whose readback is corrupted by the engine
        d0 = done_cnt;
        t0 = txn_cnt;
        eng_corrupt = 1'b1;
        w = mk(1'b1, 7'h30, 8'hA5);
        push(w);
        model_cmd(w);
        wait_idle(600);
        eng_corrupt = 1'b0;
        check("vfy_txn", 32'(txn_cnt - t0), 32'(1 + VERIFY));
        check("vfy_mismatch", 32'(err_mismatch), 32'(VERIFY));
        check("vfy_res_empty", 32'(res_empty), 32'd1);
        check("vfy_done", 32'(done_cnt - d0), 32'd1);
        pulse_clear();
        check("vfy_cleared", 32'(err_mismatch), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
